// File: rtl/supervised_regwin.sv
// Supervisor window for a Synapse316 core: NPEEK mailbox registers at the top of the
// register file, halt/step fetch gating and a host Avalon-MM slave. Optional breakpoint: SUPERVISED_REGWIN_BKPT_EN.
module supervised_regwin #(
   parameter int NREGS  = 16,
   parameter int NPEEK  = 2,
   parameter int ADDR_W = 16
) (
   input  logic                  sysclk,
   input  logic                  sysreset,
   input  logic                  mcu_wait,
   input  logic [15:0]           rom_code_in,
   input  logic                  rom_code_ready,
   input  logic [ADDR_W-1:0]     tg_code_addr,
   output logic [15:0]           tg_code_in,
   output logic                  tg_code_ready,
   input  logic [16*NREGS-1:0]   r_in,
   output logic [16*NREGS-1:0]   tg_r,
   input  logic [NREGS-1:0]      tg_r_read,
   input  logic [NREGS-1:0]      tg_r_load,
   input  logic [15:0]           r_load_data,
   output logic [NREGS-1:0]      r_read,
   output logic [NREGS-1:0]      r_load,
   input  logic [3:0]            av_address,
   input  logic                  av_read,
   input  logic                  av_write,
   input  logic [15:0]           av_writedata,
   output logic [15:0]           av_readdata,
   output logic                  av_waitrequest
);

   localparam int BASE = NREGS - NPEEK;

   logic [15:0]      peek [NPEEK];
   logic [NPEEK-1:0] dirty;
   logic             halted;
   logic             step_armed;
   logic [15:0]      fetch_cnt;

   logic             bkpt_match;
   logic             gate;
   logic             accept;
   logic [2:0]       status_bkpt;
   logic [15:0]      bkpt_rd;
   logic             unused_bkpt;
   logic [15:0]      status;
   logic [15:0]      rd_mux;

   // Host decode; halt_req beats resume when both are written together.
   logic       ctrl_wr, cnt_wr, bkpt_wr, peek_sel, peek_wr, peek_rd;
   logic       halt_req, resume, step_req;
   logic [2:0] peek_idx;

   assign ctrl_wr  = av_write && (av_address == 4'd0);
   assign bkpt_wr  = av_write && (av_address == 4'd2);
   assign cnt_wr   = av_write && (av_address == 4'd3);
   assign peek_idx = av_address[2:0];
   assign peek_sel = av_address[3] && (int'(peek_idx) < NPEEK);
   assign peek_wr  = av_write && peek_sel;
   assign peek_rd  = av_read && peek_sel;
   assign halt_req = ctrl_wr && av_writedata[0];
   assign resume   = ctrl_wr && av_writedata[1] && !av_writedata[0];
   assign step_req = ctrl_wr && av_writedata[2];

   assign gate          = mcu_wait | (halted & ~step_armed) | bkpt_match;
   assign tg_code_ready = rom_code_ready & ~gate;
   assign tg_code_in    = gate ? 16'hFFFF : rom_code_in;
   assign accept        = tg_code_ready;

   assign av_waitrequest = 1'b0;

`ifdef SUPERVISED_REGWIN_BKPT_EN
   logic              bkpt_en;
   logic              bkpt_hit;
   logic              skip;
   logic [ADDR_W-1:0] bkpt_addr;

   assign bkpt_match = bkpt_en & ~step_armed & ~skip & ~halted & (tg_code_addr == bkpt_addr);

   always_ff @(posedge sysclk) begin
      if (!sysreset) begin
         bkpt_en   <= 1'b0;
         bkpt_hit  <= 1'b0;
         skip      <= 1'b0;
         bkpt_addr <= '0;
      end else begin
         if (ctrl_wr) bkpt_en <= av_writedata[3];
         if (bkpt_wr) bkpt_addr <= ADDR_W'(av_writedata);
         if (bkpt_match) bkpt_hit <= 1'b1;
         else if (resume || step_req) bkpt_hit <= 1'b0;
         // skip masks the compare until the core actually takes the resumed fetch
         if (resume) skip <= 1'b1;
         else if (accept) skip <= 1'b0;
      end
   end

   assign status_bkpt = {bkpt_en, 1'b0, bkpt_hit};
   assign bkpt_rd     = 16'(bkpt_addr);
   assign unused_bkpt = 1'b0;
`else
   assign bkpt_match  = 1'b0;
   assign status_bkpt = 3'b000;
   assign bkpt_rd     = 16'h0000;
   assign unused_bkpt = ^tg_code_addr;
`endif

   // NOTE: state uses <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge sysclk) begin
      if (!sysreset) begin
         halted     <= 1'b0;
         step_armed <= 1'b0;
         fetch_cnt  <= 16'h0000;
         dirty      <= '0;
         // NOTE: the mailbox array is architecturally visible after reset, so it is reset too.
         for (int k = 0; k < NPEEK; k++) peek[k] <= 16'h0000;
      end else begin
         if (halt_req || bkpt_match) halted <= 1'b1;
         else if (resume) halted <= 1'b0;

         if (step_req && halted) step_armed <= 1'b1;
         else if (accept) step_armed <= 1'b0;

         if (cnt_wr) fetch_cnt <= 16'h0000;
         else if (accept) fetch_cnt <= fetch_cnt + 16'd1;

         // core load beats host poke; a host read only clears dirty if no load lands
         for (int k = 0; k < NPEEK; k++) begin
            if (tg_r_load[BASE+k]) begin
               peek[k]  <= r_load_data;
               dirty[k] <= 1'b1;
            end else begin
               if (peek_wr && peek_idx == 3'(k)) peek[k] <= av_writedata;
               if (peek_rd && peek_idx == 3'(k)) dirty[k] <= 1'b0;
            end
         end
      end
   end

   assign status = {8'(dirty), 4'b0000, status_bkpt, halted};

   // NOTE: rd_mux gets a default first so no path through the case can infer a latch.
   always_comb begin
      rd_mux = 16'h0000;
      case (av_address)
         4'd1:    rd_mux = status;
         4'd2:    rd_mux = bkpt_rd;
         4'd3:    rd_mux = fetch_cnt;
         default: begin
            for (int k = 0; k < NPEEK; k++)
               if (peek_sel && peek_idx == 3'(k)) rd_mux = peek[k];
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!sysreset) av_readdata <= 16'h0000;
      else if (av_read) av_readdata <= rd_mux;
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_regs
      if (i < BASE) begin : g_pass
         assign tg_r[16*i +: 16] = r_in[16*i +: 16];
         assign r_read[i]        = tg_r_read[i];
         assign r_load[i]        = tg_r_load[i];
      end else begin : g_peek
         assign tg_r[16*i +: 16] = peek[i-BASE];
         assign r_read[i]        = 1'b0;
         assign r_load[i]        = 1'b0;
      end
   end

   logic unused_inputs;
   assign unused_inputs = ^{r_in[16*NREGS-1:16*BASE], tg_r_read[NREGS-1:BASE], unused_bkpt};

endmodule

// File: tb/tb_supervised_regwin.sv
// Self-checking bench for supervised_regwin (NREGS=16, NPEEK=2): event-level model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_supervised_regwin;

   localparam int NREGS = 16;
   localparam int NPEEK = 2;
   localparam int BASE  = NREGS - NPEEK;
`ifdef SUPERVISED_REGWIN_BKPT_EN
   localparam bit BK = 1'b1;
`else
   localparam bit BK = 1'b0;
`endif

   logic                 sysclk = 1'b0;
   logic                 sysreset;
   logic                 mcu_wait;
   logic [15:0]          rom_code_in;
   logic                 rom_code_ready;
   logic [15:0]          tg_code_addr;
   logic [15:0]          tg_code_in;
   logic                 tg_code_ready;
   logic [16*NREGS-1:0]  r_in;
   logic [16*NREGS-1:0]  tg_r;
   logic [NREGS-1:0]     tg_r_read;
   logic [NREGS-1:0]     tg_r_load;
   logic [15:0]          r_load_data;
   logic [NREGS-1:0]     r_read;
   logic [NREGS-1:0]     r_load;
   logic [3:0]           av_address;
   logic                 av_read;
   logic                 av_write;
   logic [15:0]          av_writedata;
   logic [15:0]          av_readdata;
   logic                 av_waitrequest;

   supervised_regwin #(.NREGS(NREGS), .NPEEK(NPEEK), .ADDR_W(16)) dut (
      .sysclk(sysclk), .sysreset(sysreset), .mcu_wait(mcu_wait),
      .rom_code_in(rom_code_in), .rom_code_ready(rom_code_ready),
      .tg_code_addr(tg_code_addr), .tg_code_in(tg_code_in), .tg_code_ready(tg_code_ready),
      .r_in(r_in), .tg_r(tg_r), .tg_r_read(tg_r_read), .tg_r_load(tg_r_load),
      .r_load_data(r_load_data), .r_read(r_read), .r_load(r_load),
      .av_address(av_address), .av_read(av_read), .av_write(av_write),
      .av_writedata(av_writedata), .av_readdata(av_readdata), .av_waitrequest(av_waitrequest)
   );

   always #5 sysclk = ~sysclk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_peek [NPEEK];
   bit          m_dirty [NPEEK];
   bit          m_halted, m_step, m_skip, m_hit, m_en;
   logic [15:0] m_bkpt, m_cnt, m_rd;

   function automatic bit m_match();
      return BK && m_en && !m_step && !m_skip && !m_halted && (tg_code_addr == m_bkpt);
   endfunction

   function automatic bit m_gate();
      return mcu_wait || (m_halted && !m_step) || m_match();
   endfunction

   function automatic logic [15:0] m_read(input logic [3:0] a);
      logic [15:0] v = 16'h0000;
      if (a == 4'd1) begin
         for (int k = 0; k < NPEEK; k++) v[8+k] = m_dirty[k];
         v[0] = m_halted;
         v[1] = BK && m_hit;
         v[3] = BK && m_en;
      end else if (a == 4'd2) v = BK ? m_bkpt : 16'h0000;
      else if (a == 4'd3) v = m_cnt;
      else if (a >= 4'd8 && int'(a) - 8 < NPEEK) v = m_peek[int'(a) - 8];
      return v;
   endfunction

   always @(posedge sysclk) begin
      if (!sysreset) begin
         for (int k = 0; k < NPEEK; k++) begin m_peek[k] = 16'h0; m_dirty[k] = 0; end
         {m_halted, m_step, m_skip, m_hit, m_en} = '0;
         m_bkpt = 16'h0; m_cnt = 16'h0; m_rd = 16'h0;
      end else begin
         bit was_halted, fetched, matched;
         was_halted = m_halted;
         fetched    = rom_code_ready && !m_gate();
         matched    = m_match();
         if (av_read) m_rd = m_read(av_address);
         // an accepted fetch counts, and ends any step release or resume skip
         if (fetched) begin m_cnt++; m_step = 0; m_skip = 0; end
         if (av_write) begin
            case (av_address)
               4'd0: begin
                  m_en = av_writedata[3];
                  if (av_writedata[0]) m_halted = 1;
                  else if (av_writedata[1]) begin m_halted = 0; m_skip = BK; m_hit = 0; end
                  if (av_writedata[2]) begin m_hit = 0; if (was_halted) m_step = 1; end
               end
               4'd2: m_bkpt = av_writedata;
               4'd3: m_cnt = 16'h0;
               default: if (av_address >= 4'd8 && int'(av_address) - 8 < NPEEK)
                  m_peek[int'(av_address) - 8] = av_writedata;
            endcase
         end
         if (av_read && av_address >= 4'd8 && int'(av_address) - 8 < NPEEK)
            m_dirty[int'(av_address) - 8] = 0;
         for (int k = 0; k < NPEEK; k++)
            if (tg_r_load[BASE+k]) begin m_peek[k] = r_load_data; m_dirty[k] = 1; end
         if (matched) begin m_halted = 1; m_hit = 1; end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge sysclk) begin
      if (cmp_on) begin
         bit g;
         g = m_gate();
         check("tg_code_ready", 32'(tg_code_ready), 32'(rom_code_ready && !g));
         check("tg_code_in", 32'(tg_code_in), 32'(g ? 16'hFFFF : rom_code_in));
         check("av_readdata", 32'(av_readdata), 32'(m_rd));
         check("av_waitrequest", 32'(av_waitrequest), 32'h0);
         check("r_read", 32'(r_read), 32'(tg_r_read & 16'h3FFF));
         check("r_load", 32'(r_load), 32'(tg_r_load & 16'h3FFF));
         for (int i = 0; i < NREGS; i++)
            check($sformatf("tg_r[%0d]", i), 32'(tg_r[16*i +: 16]),
                  32'(i < BASE ? r_in[16*i +: 16] : m_peek[i-BASE]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge sysclk); #1;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [15:0] d);
      av_address = a; av_writedata = d; av_write = 1'b1;
      tick();
      av_write = 1'b0;
   endtask

   task automatic host_read(input logic [3:0] a, output logic [15:0] d);
      av_address = a; av_read = 1'b1;
      tick();
      av_read = 1'b0;
      d = av_readdata;
   endtask

   task automatic watch(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(negedge sysclk);
         if (tg_code_ready) pulses++;
         @(posedge sysclk); #1;
      end
   endtask

   initial begin
      logic [15:0] rd;
      int          p;

      sysreset = 1'b0; mcu_wait = 1'b0; rom_code_in = 16'h5A00; rom_code_ready = 1'b1;
      tg_code_addr = 16'h0010; tg_r_read = 16'hC00F; tg_r_load = '0; r_load_data = '0;
      av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
      for (int i = 0; i < NREGS; i++) r_in[16*i +: 16] = 16'hA000 + 16'(i);

      tick();
      cmp_on = 1'b1;
      tick();
      sysreset = 1'b1;
      host_read(4'd1, rd);           check("reset STATUS", 32'(rd), 32'h0000);

      // core load into the top register sets dirty[1]; a host read returns it and clears dirty
      tg_r_load = 16'h8001; r_load_data = 16'h1234;
      tick();
      tg_r_load = '0;
      host_read(4'd1, rd);           check("STATUS dirty1", 32'(rd), 32'h0200);
      host_read(4'd9, rd);           check("PEEK1 read", 32'(rd), 32'h1234);
      host_read(4'd1, rd);           check("STATUS dirty cleared", 32'(rd), 32'h0000);

      // host poke is visible to the core and leaves dirty alone
      host_write(4'd8, 16'hBEEF);
      check("tg_r poke", 32'(tg_r[16*14 +: 16]), 32'h0000BEEF);
      host_read(4'd1, rd);           check("STATUS after poke", 32'(rd), 32'h0000);

      // core load vs host write, then core load vs host read, on the same PEEK
      tg_r_load = 16'h4000; r_load_data = 16'h5555;
      host_write(4'd8, 16'h6666);
      tg_r_load = '0;
      check("load beats poke", 32'(tg_r[16*14 +: 16]), 32'h00005555);
      tg_r_load = 16'h4000; r_load_data = 16'h7777;
      host_read(4'd8, rd);
      tg_r_load = '0;
      check("read old value", 32'(rd), 32'h5555);
      host_read(4'd1, rd);           check("dirty kept on collision", 32'(rd), 32'h0100);
      host_read(4'd8, rd);           check("PEEK0 new value", 32'(rd), 32'h7777);

      // unmapped and write-only addresses read 0
      host_write(4'd12, 16'h1234);
      host_read(4'd12, rd);          check("unmapped 12", 32'(rd), 32'h0000);
      host_read(4'd5, rd);           check("unmapped 5", 32'(rd), 32'h0000);
      host_read(4'd0, rd);           check("CTRL read", 32'(rd), 32'h0000);

      // breakpoint at 0x0040
      host_write(4'd2, 16'h0040);
      host_write(4'd0, 16'h0008);
      host_read(4'd2, rd);           check("BKPT_ADDR", 32'(rd), BK ? 32'h0040 : 32'h0000);
      rom_code_in = 16'hC0DE;
      tg_code_addr = 16'h003E; tick();
      tg_code_addr = 16'h003F; tick();
      tg_code_addr = 16'h0040;
      @(negedge sysclk); #1;
      check("bkpt ready", 32'(tg_code_ready), BK ? 32'h0 : 32'h1);
      check("bkpt code_in", 32'(tg_code_in), BK ? 32'hFFFF : 32'hC0DE);
      @(posedge sysclk); #1;
      host_read(4'd1, rd);           check("bkpt STATUS", 32'(rd), BK ? 32'h000B : 32'h0000);

      // single step from the halt at 0x0040
      host_write(4'd0, 16'h0009);
      host_write(4'd3, 16'h0000);
      host_write(4'd0, 16'h000C);
      watch(6, p);                   check("step pulses", 32'(p), 32'd1);
      host_read(4'd1, rd);           check("step STATUS", 32'(rd), BK ? 32'h0009 : 32'h0001);
      host_read(4'd3, rd);           check("step FETCH_CNT", 32'(rd), 32'h0001);

      // resume at the breakpoint address must not retrigger
      host_write(4'd0, 16'h000A);
      @(negedge sysclk); #1;
      check("resume no retrigger", 32'(tg_code_ready), 32'h1);
      tg_code_addr = 16'h0041;
      @(posedge sysclk); #1;
      host_read(4'd1, rd);           check("resume STATUS", 32'(rd), BK ? 32'h0008 : 32'h0000);

      // step while running is ignored
      host_write(4'd0, 16'h0004);
      host_write(4'd0, 16'h0001);
      watch(3, p);                   check("ignored step", 32'(p), 32'd0);

      // step waits out mcu_wait
      mcu_wait = 1'b1;
      host_write(4'd0, 16'h0004);
      watch(4, p);                   check("step under wait", 32'(p), 32'd0);
      check("wait code_in", 32'(tg_code_in), 32'hFFFF);
      mcu_wait = 1'b0;
      watch(4, p);                   check("step after wait", 32'(p), 32'd1);

      // halt and resume in one write: halt wins
      host_write(4'd0, 16'h0002);
      host_write(4'd0, 16'h0003);
      host_read(4'd1, rd);           check("halt beats resume", 32'(rd), 32'h0001);

      // reset while halted with dirty set
      tg_r_load = 16'h8000; r_load_data = 16'hAAAA;
      tick();
      tg_r_load = '0;
      host_read(4'd1, rd);           check("pre-reset STATUS", 32'(rd), 32'h0201);
      sysreset = 1'b0;
      tick();
      sysreset = 1'b1;
      @(negedge sysclk); #1;
      check("post-reset ready", 32'(tg_code_ready), 32'h1);
      @(posedge sysclk); #1;
      host_read(4'd1, rd);           check("post-reset STATUS", 32'(rd), 32'h0000);
      host_read(4'd9, rd);           check("post-reset PEEK1", 32'(rd), 32'h0000);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
